// File: rtl/vmerge_mask_seq_pkg.sv
// Shared definitions for the vector merge mask sequencer: FSM state codes
// and the elements-per-beat helper.
package vmerge_mask_seq_pkg;

    localparam int unsigned STATE_WIDTH = 2;

    localparam logic [STATE_WIDTH-1:0] ST_IDLE      = 2'd0;
    localparam logic [STATE_WIDTH-1:0] ST_WAIT_MASK = 2'd1;
    localparam logic [STATE_WIDTH-1:0] ST_RUN       = 2'd2;

    // Elements carried by one beat: bytes per beat divided by element bytes.
    function automatic int unsigned sew_epb(input int unsigned mask_width,
                                            input logic [1:0] sew);
        return mask_width >> sew;
    endfunction

endpackage

// File: rtl/vmask_byte_expand.sv
// Expands element mask bits to byte selects for one beat and forces tail
// elements (index >= vl) to select vec0.
module vmask_byte_expand #(
    parameter int unsigned MASK_WIDTH  = 8,
    parameter int unsigned MWORD_WIDTH = 64,
    parameter int unsigned VL_WIDTH    = 11,
    parameter int unsigned SEW_WIDTH   = 2,
    localparam int unsigned BP_WIDTH   = $clog2(MWORD_WIDTH)
) (
    input  logic [MWORD_WIDTH-1:0] mreg,
    input  logic [BP_WIDTH-1:0]    bit_ptr,
    input  logic [VL_WIDTH-1:0]    elem_ptr,
    input  logic [VL_WIDTH-1:0]    vl,
    input  logic [SEW_WIDTH-1:0]   sew,
    output logic [MASK_WIDTH-1:0]  mask_c
);

    localparam int unsigned EXT_WIDTH = VL_WIDTH + 1;

    // Element index widened by one bit so the tail test cannot overflow.
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            mask_c[i] = mreg[bit_ptr + BP_WIDTH'(i >> sew)]
                      & ((EXT_WIDTH'(elem_ptr) + EXT_WIDTH'(i >> sew)) < EXT_WIDTH'(vl));
        end
    end

endmodule

// File: rtl/vmerge_mask_seq.sv
// Feeds the vector merge stage: walks operand beats of one merge instruction,
// pulling v0 mask words as needed and emitting byte-select masks per beat.
module vmerge_mask_seq
    import vmerge_mask_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned MASK_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MWORD_WIDTH = 64,
    parameter int unsigned VL_WIDTH    = 11,
    parameter int unsigned SEW_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [VL_WIDTH-1:0]    start_vl,
    input  logic [SEW_WIDTH-1:0]   start_sew,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    output logic                   busy,
    output logic                   done,
    input  logic [MWORD_WIDTH-1:0] mword,
    input  logic                   mword_valid,
    output logic                   mword_ready,
    input  logic [DATA_WIDTH-1:0]  in_vec0,
    input  logic [DATA_WIDTH-1:0]  in_vec1,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [MASK_WIDTH-1:0]  out_mask,
    output logic [DATA_WIDTH-1:0]  out_vec0,
    output logic [DATA_WIDTH-1:0]  out_vec1,
    output logic                   out_valid,
    output logic                   out_last
);

    localparam int unsigned BP_WIDTH  = $clog2(MWORD_WIDTH);
    localparam int unsigned EXT_WIDTH = VL_WIDTH + 1;

    logic [STATE_WIDTH-1:0] state, state_next;
    logic [VL_WIDTH-1:0]    vl_q, elem_ptr;
    logic [SEW_WIDTH-1:0]   sew_q;
    logic [ADDR_WIDTH-1:0]  base_q, beat_cnt;
    logic [BP_WIDTH-1:0]    bit_ptr, bit_ptr_next;
    logic [MWORD_WIDTH-1:0] mreg;
    logic [MASK_WIDTH-1:0]  mask_c;
    logic [EXT_WIDTH-1:0]   epb_c;
    logic                   beat_last_c;
    logic                   start_go, start_zero, mword_take, beat_take;

    vmask_byte_expand #(
        .MASK_WIDTH (MASK_WIDTH),
        .MWORD_WIDTH(MWORD_WIDTH),
        .VL_WIDTH   (VL_WIDTH),
        .SEW_WIDTH  (SEW_WIDTH)
    ) u_expand (
        .mreg    (mreg),
        .bit_ptr (bit_ptr),
        .elem_ptr(elem_ptr),
        .vl      (vl_q),
        .sew     (sew_q),
        .mask_c  (mask_c)
    );

    assign epb_c        = EXT_WIDTH'(sew_epb(MASK_WIDTH, sew_q));
    assign bit_ptr_next = bit_ptr + BP_WIDTH'(epb_c);
    assign beat_last_c  = (EXT_WIDTH'(elem_ptr) + epb_c) >= EXT_WIDTH'(vl_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle event decode.
    always_comb begin
        state_next = state;
        start_go   = 1'b0;
        start_zero = 1'b0;
        mword_take = 1'b0;
        beat_take  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (start_vl != '0) begin
                        start_go   = 1'b1;
                        state_next = ST_WAIT_MASK;
                    end else begin
                        start_zero = 1'b1;
                    end
                end
            end
            ST_WAIT_MASK: begin
                if (mword_valid) begin
                    mword_take = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    beat_take = 1'b1;
                    if (beat_last_c) begin
                        state_next = ST_IDLE;
                    end else if (bit_ptr_next == '0) begin
                        state_next = ST_WAIT_MASK;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they match the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            mword_ready <= 1'b0;
            in_ready    <= 1'b0;
            out_addr    <= '0;
            out_mask    <= '0;
            out_vec0    <= '0;
            out_vec1    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            vl_q        <= '0;
            sew_q       <= '0;
            base_q      <= '0;
            elem_ptr    <= '0;
            bit_ptr     <= '0;
            beat_cnt    <= '0;
            mreg        <= '0;
        end else begin
            busy        <= (state_next != ST_IDLE);
            mword_ready <= (state_next == ST_WAIT_MASK);
            in_ready    <= (state_next == ST_RUN);
            done        <= start_zero | (beat_take & beat_last_c);
            out_valid   <= beat_take;
            out_last    <= beat_take & beat_last_c;
            out_mask    <= beat_take ? mask_c : '0;
            out_vec0    <= beat_take ? in_vec0 : '0;
            out_vec1    <= beat_take ? in_vec1 : '0;
            out_addr    <= beat_take ? (base_q + beat_cnt) : '0;
            if (start_go) begin
                vl_q     <= start_vl;
                sew_q    <= start_sew;
                base_q   <= start_addr;
                elem_ptr <= '0;
                bit_ptr  <= '0;
                beat_cnt <= '0;
            end
            if (mword_take) begin
                mreg <= mword;
            end
            if (beat_take) begin
                elem_ptr <= elem_ptr + VL_WIDTH'(epb_c);
                bit_ptr  <= bit_ptr_next;
                beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_vmerge_mask_seq.sv
// Directed bench for vmerge_mask_seq: table of single-beat instructions plus
// hand-written multi-beat, wait, reset and vl=0 sequences.
module tb_vmerge_mask_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] start_vl;
    logic [1:0]  start_sew;
    logic [31:0] start_addr;
    logic        busy, done;
    logic [63:0] mword;
    logic        mword_valid, mword_ready;
    logic [63:0] in_vec0, in_vec1;
    logic        in_valid, in_ready;
    logic [31:0] out_addr;
    logic [7:0]  out_mask;
    logic [63:0] out_vec0, out_vec1;
    logic        out_valid, out_last;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vmerge_mask_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_vl   (start_vl),
        .start_sew  (start_sew),
        .start_addr (start_addr),
        .busy       (busy),
        .done       (done),
        .mword      (mword),
        .mword_valid(mword_valid),
        .mword_ready(mword_ready),
        .in_vec0    (in_vec0),
        .in_vec1    (in_vec1),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_addr   (out_addr),
        .out_mask   (out_mask),
        .out_vec0   (out_vec0),
        .out_vec1   (out_vec1),
        .out_valid  (out_valid),
        .out_last   (out_last)
    );

    typedef struct {
        logic [1:0]  sew;
        logic [10:0] vl;
        logic [31:0] addr;
        logic [63:0] mw;
        logic [63:0] v0;
        logic [63:0] v1;
        logic [7:0]  mask;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Issue a start and supply the first mask word; returns with the DUT in RUN.
    task automatic load_instr(input logic [1:0] sew, input logic [10:0] vl,
                              input logic [31:0] addr, input logic [63:0] mw);
        start = 1'b1; start_sew = sew; start_vl = vl; start_addr = addr;
        tick();
        start = 1'b0;
        check("wait_mword_ready", 64'(mword_ready), 64'd1);
        mword_valid = 1'b1; mword = mw;
        tick();
        mword_valid = 1'b0;
        check("run_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w0, w1;
        logic        ebit;
        int          seen, lasts, dones, cyc;

        tbl[0] = '{2'd0, 11'd8, 32'h0000_1000, 64'h0000_0000_0000_00A5, 64'h0,                   ~64'h0,                 8'hA5};
        tbl[1] = '{2'd0, 11'd5, 32'h0000_2000, 64'h0000_0000_0000_00FF, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 8'h1F};
        tbl[2] = '{2'd1, 11'd3, 32'h0000_3000, 64'hFFFF_FFFF_FFFF_FFF5, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 8'h33};
        tbl[3] = '{2'd2, 11'd2, 32'h0000_4000, 64'h0000_0000_0000_0002, 64'hAAAA_0000_BBBB_0000, 64'h0000_CCCC_0000_DDDD, 8'hF0};
        tbl[4] = '{2'd2, 11'd1, 32'h0000_5000, 64'h0000_0000_0000_0003, 64'h1,                   64'h2,                  8'h0F};
        tbl[5] = '{2'd3, 11'd1, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 64'h3,                   64'h4,                  8'hFF};
        tbl[6] = '{2'd3, 11'd1, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFFE, 64'h5,                   64'h6,                  8'h00};
        tbl[7] = '{2'd0, 11'd1, 32'h0000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7,                   64'h8,                  8'h01};

        rst = 1'b1; start = 1'b0; start_vl = '0; start_sew = '0; start_addr = '0;
        mword = '0; mword_valid = 1'b0; in_vec0 = '0; in_vec1 = '0; in_valid = 1'b0;
        tick(); tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mword_ready", 64'(mword_ready), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        tick();

        // Single-beat instructions from the table.
        for (int k = 0; k < 8; k++) begin
            load_instr(tbl[k].sew, tbl[k].vl, tbl[k].addr, tbl[k].mw);
            in_valid = 1'b1; in_vec0 = tbl[k].v0; in_vec1 = tbl[k].v1;
            tick();
            in_valid = 1'b0;
            check($sformatf("t%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("t%0d_mask", k), 64'(out_mask), 64'(tbl[k].mask));
            check($sformatf("t%0d_last", k), 64'(out_last), 64'd1);
            check($sformatf("t%0d_done", k), 64'(done), 64'd1);
            check($sformatf("t%0d_addr", k), 64'(out_addr), 64'(tbl[k].addr));
            check($sformatf("t%0d_vec0", k), out_vec0, tbl[k].v0);
            check($sformatf("t%0d_vec1", k), out_vec1, tbl[k].v1);
            check($sformatf("t%0d_busy", k), 64'(busy), 64'd0);
            tick();
            check($sformatf("t%0d_done_pulse", k), 64'(done), 64'd0);
            check($sformatf("t%0d_valid_pulse", k), 64'(out_valid), 64'd0);
        end

        // sew=16b, vl=6, two beats, address wraps past 2^32-1.
        load_instr(2'd1, 11'd6, 32'hFFFF_FFFF, 64'h0000_0000_0000_00FD);
        in_valid = 1'b1; in_vec0 = 64'hA0; in_vec1 = 64'hB0;
        tick();
        in_vec0 = 64'hA1; in_vec1 = 64'hB1;
        check("s16_b0_mask", 64'(out_mask), 64'hF3);
        check("s16_b0_last", 64'(out_last), 64'd0);
        check("s16_b0_done", 64'(done), 64'd0);
        check("s16_b0_addr", 64'(out_addr), 64'hFFFF_FFFF);
        check("s16_b0_vec1", out_vec1, 64'hB0);
        tick();
        in_valid = 1'b0;
        check("s16_b1_valid", 64'(out_valid), 64'd1);
        check("s16_b1_mask", 64'(out_mask), 64'h0F);
        check("s16_b1_last", 64'(out_last), 64'd1);
        check("s16_b1_done", 64'(done), 64'd1);
        check("s16_b1_addr", 64'(out_addr), 64'h0);
        check("s16_b1_vec0", out_vec0, 64'hA1);
        tick();
        check("s16_idle_valid", 64'(out_valid), 64'd0);

        // sew=64b, vl=70: crosses a mask word boundary with a delayed second word.
        w0 = 64'hAAAA_AAAA_AAAA_AAAA;
        w1 = 64'h0000_0000_0000_0015;
        seen = 0; lasts = 0; dones = 0; cyc = 0;
        load_instr(2'd3, 11'd70, 32'h0000_0200, w0);
        in_valid = 1'b1; in_vec0 = 64'h55; in_vec1 = 64'h66;
        while (seen < 64 && cyc < 200) begin
            tick(); cyc++;
            if (done) dones++;
            if (out_valid) begin
                ebit = w0[seen];
                if (out_mask !== (ebit ? 8'hFF : 8'h00) || out_addr !== 32'h200 + 32'(seen) || out_last !== 1'b0)
                    check($sformatf("s64_beat%0d", seen), {out_last, 23'd0, out_mask, out_addr}, {1'b0, 23'd0, (ebit ? 8'hFF : 8'h00), 32'h200 + 32'(seen)});
                else
                    n_cmp++;
                if (out_last) lasts++;
                seen++;
            end
        end
        check("s64_first_word_beats", 64'(seen), 64'd64);
        check("s64_in_ready_drop", 64'(in_ready), 64'd0);
        check("s64_mword_ready", 64'(mword_ready), 64'd1);
        for (int c = 0; c < 5; c++) begin
            start = (c == 0); start_vl = 11'd1; start_sew = 2'd0;
            tick();
            start = 1'b0;
            check($sformatf("s64_wait%0d_valid", c), 64'(out_valid), 64'd0);
            check($sformatf("s64_wait%0d_mword_ready", c), 64'(mword_ready), 64'd1);
        end
        mword_valid = 1'b1; mword = w1;
        tick();
        mword_valid = 1'b0;
        cyc = 0;
        while (seen < 70 && cyc < 200) begin
            tick(); cyc++;
            if (done) dones++;
            if (out_valid) begin
                ebit = w1[seen - 64];
                check($sformatf("s64_beat%0d_mask", seen), 64'(out_mask), ebit ? 64'hFF : 64'h00);
                check($sformatf("s64_beat%0d_addr", seen), 64'(out_addr), 64'(32'h200 + 32'(seen)));
                check($sformatf("s64_beat%0d_last", seen), 64'(out_last), (seen == 69) ? 64'd1 : 64'd0);
                if (out_last) begin
                    lasts++;
                    check("s64_done_with_last", 64'(done), 64'd1);
                end
                seen++;
            end
        end
        in_valid = 1'b0;
        check("s64_total_beats", 64'(seen), 64'd70);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done) dones++;
            check($sformatf("s64_after%0d_valid", c), 64'(out_valid), 64'd0);
        end
        check("s64_last_count", 64'(lasts), 64'd1);
        check("s64_done_count", 64'(dones), 64'd1);
        check("s64_busy_end", 64'(busy), 64'd0);

        // vl=0 completes immediately.
        start = 1'b1; start_vl = 11'd0; start_sew = 2'd0; start_addr = 32'h40;
        tick();
        start = 1'b0;
        check("vl0_done", 64'(done), 64'd1);
        check("vl0_busy", 64'(busy), 64'd0);
        check("vl0_valid", 64'(out_valid), 64'd0);
        tick();
        check("vl0_done_pulse", 64'(done), 64'd0);
        check("vl0_mword_ready", 64'(mword_ready), 64'd0);

        // Reset after three beats of a vl=32 sew=8b instruction.
        seen = 0; cyc = 0;
        load_instr(2'd0, 11'd32, 32'h0000_0300, 64'h0000_0000_FFFF_FFFF);
        in_valid = 1'b1; in_vec0 = 64'h77; in_vec1 = 64'h88;
        while (seen < 3 && cyc < 50) begin
            tick(); cyc++;
            if (out_valid) seen++;
        end
        check("rstmid_beats", 64'(seen), 64'd3);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        check("rstmid_valid", 64'(out_valid), 64'd0);
        check("rstmid_mask", 64'(out_mask), 64'd0);
        check("rstmid_addr", 64'(out_addr), 64'd0);
        check("rstmid_vec1", out_vec1, 64'd0);
        check("rstmid_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        tick();
        check("rstmid_no_done", 64'(done), 64'd0);
        load_instr(2'd0, 11'd8, 32'h0000_0400, 64'h0000_0000_0000_003C);
        in_valid = 1'b1; in_vec0 = 64'h9; in_vec1 = 64'hA;
        tick();
        in_valid = 1'b0;
        check("rstnew_mask", 64'(out_mask), 64'h3C);
        check("rstnew_addr", 64'(out_addr), 64'h400);
        check("rstnew_last", 64'(out_last), 64'd1);
        check("rstnew_done", 64'(done), 64'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
